// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - flit format shared by the NI link blocks
package noc_flit_pkg;

  localparam int FLIT_W  = 48;
  localparam int TYPE_HI = 47;
  localparam int TYPE_LO = 46;
  localparam int DEST_HI = 45;
  localparam int DEST_LO = 38;
  localparam int SRC_HI  = 37;
  localparam int SRC_LO  = 30;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } link_state_e;

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating credit counter with sticky overflow
// A credit is returned (inc), refunded on a drop (refund) or consumed (dec) in one step.
module credit_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         refund,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W+1:0] MAX_V = (W+2)'(MAX);

  logic [W+1:0] sum;

  // dec is only ever asserted with count != 0, so sum cannot underflow
  assign sum = {2'b00, count} + {{(W+1){1'b0}}, inc}
             + {{(W+1){1'b0}}, refund} - {{(W+1){1'b0}}, dec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= W'(MAX);
      overflow <= 1'b0;
    end else if (sum > MAX_V) begin
      count    <= W'(MAX);
      overflow <= 1'b1;
    end else begin
      count    <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/flit_link_tx.sv
// rtl/flit_link_tx.sv - credit-based NI-to-router flit transmitter
// Pops the NI FIFO, checks head/body/tail framing and forwards flits two cycles after the pop.
module flit_link_tx
  import noc_flit_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_enable,
  input  logic [FLIT_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_read_enable,
  output logic [FLIT_W-1:0] link_flit,
  output logic              link_valid,
  input  logic              link_credit,
  output logic [CNT_W-1:0]  credit_count,
  output logic              in_packet,
  output logic [15:0]       pkt_count,
  output logic              proto_err,
  output logic              credit_err
);

  link_state_e state, nxt_state;
  flit_type_e  ftype;
  logic        pop, pend;
  logic        fwd, drop, done, perr;

  assign pop              = link_enable & ~fifo_empty & (credit_count != '0);
  assign fifo_read_enable = pop;
  assign in_packet        = (state == ST_PKT);
  assign ftype            = flit_type_e'(fifo_data[TYPE_HI:TYPE_LO]);

  // Classification of the flit returned by last cycle's pop
  always_comb begin
    nxt_state = state;
    fwd       = 1'b0;
    drop      = 1'b0;
    done      = 1'b0;
    perr      = 1'b0;
    if (pend) begin
      if (state == ST_IDLE) begin
        case (ftype)
          FT_HEAD:   begin fwd = 1'b1; nxt_state = ST_PKT; end
          FT_SINGLE: begin fwd = 1'b1; done = 1'b1; end
          default:   begin drop = 1'b1; perr = 1'b1; end
        endcase
      end else begin
        fwd = 1'b1;
        case (ftype)
          FT_BODY:   ;
          FT_TAIL:   begin done = 1'b1; nxt_state = ST_IDLE; end
          FT_HEAD:   perr = 1'b1;
          default:   begin perr = 1'b1; done = 1'b1; nxt_state = ST_IDLE; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pend       <= 1'b0;
      link_valid <= 1'b0;
      link_flit  <= '0;
      pkt_count  <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= nxt_state;
      pend       <= pop;
      link_valid <= fwd;
      if (fwd)  link_flit <= fifo_data;
      if (done) pkt_count <= pkt_count + 16'd1;
      if (perr) proto_err <= 1'b1;
    end
  end

  credit_counter #(
    .MAX (CREDITS),
    .W   (CNT_W)
  ) u_credit_counter (
    .clk      (clk),
    .rst_n    (reset),
    .inc      (link_credit),
    .refund   (drop),
    .dec      (pop),
    .count    (credit_count),
    .overflow (credit_err)
  );

endmodule
